alu_shift_sequencer: RTL and testbench

Multi-bit shift sequencer for the 16-bit datapath. It wraps the ALU's single-bit shift path by loading an operand, driving it onto the ALU `a` input, and capturing the ALU's `yout` and `cout` once per clock. It repeats this `amount` times, then presents the shifted result, last carry-out and zero flag. It sits directly upstream and downstream of the ALU: it feeds `a`, `f` and `notShiftOE`, and consumes `yout` and `cout`.

---
 rtl/alu_shift_sequencer_if.sv | 28 ++
 rtl/alu_shift_sequencer.sv | 73 +++++++
 tb/tb_alu_shift_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_sequencer_if.sv
// Request/response bus and ALU shift link for alu_shift_sequencer.
// The master side is the requester together with the ALU. The slave side is the sequencer.
interface alu_shift_sequencer_if;
    logic        start;
    logic        dir;
    logic [3:0]  amount;
    logic [15:0] operand;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic [15:0] alu_a;
    logic [4:0]  alu_f;
    logic        alu_notShiftOE;
    logic [15:0] alu_y;
    logic        alu_cout;

    modport master (
        output start, dir, amount, operand, alu_y, alu_cout,
        input  busy, done, result, carry, zero, alu_a, alu_f, alu_notShiftOE
    );

    modport slave (
        input  start, dir, amount, operand, alu_y, alu_cout,
        output busy, done, result, carry, zero, alu_a, alu_f, alu_notShiftOE
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shift sequencer for the 16-bit datapath.
// It steps the ALU single-bit shifter once per clock, `amount` times.
module alu_shift_sequencer (
    input  logic                  clk,
    input  logic                  notReset,
    alu_shift_sequencer_if.slave  bus
);
    // Function codes shared with the ALU
    localparam logic [4:0] AluFShiftLeft  = 5'h0C;
    localparam logic [4:0] AluFShiftRight = 5'h0D;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q;
    logic [15:0] acc_q;
    logic [3:0]  cnt_q;
    logic        dir_q;
    logic [15:0] result_q;
    logic        carry_q;

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state_q  <= StIdle;
            acc_q    <= 16'h0000;
            cnt_q    <= 4'd0;
            dir_q    <= 1'b0;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        acc_q <= bus.operand;
                        cnt_q <= bus.amount;
                        dir_q <= bus.dir;
                        if (bus.amount != 4'd0) begin
                            state_q <= StShift;
                        end else begin
                            // Zero-length shift: operand passes straight through, no bit shifted out
                            state_q  <= StDone;
                            result_q <= bus.operand;
                            carry_q  <= 1'b0;
                        end
                    end
                end
                StShift: begin
                    acc_q <= bus.alu_y;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q  <= StDone;
                        result_q <= bus.alu_y;
                        carry_q  <= bus.alu_cout;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy           = (state_q != StIdle);
    assign bus.done           = (state_q == StDone);
    assign bus.alu_notShiftOE = (state_q != StShift);
    assign bus.alu_a          = acc_q;
    assign bus.alu_f          = dir_q ? AluFShiftLeft : AluFShiftRight;
    assign bus.result         = result_q;
    assign bus.carry          = carry_q;
    assign bus.zero           = (result_q == 16'h0000);
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Scoreboard bench for alu_shift_sequencer with a behavioural single-bit ALU shifter.
module tb_alu_shift_sequencer;
    localparam logic [4:0] FLeft  = 5'h0C;
    localparam logic [4:0] FRight = 5'h0D;

    typedef struct {
        logic [15:0] res;
        logic        cy;
        logic        d;
        int          amt;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic notReset = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;
    int   oe_cnt = 0;
    exp_t q[$];

    alu_shift_sequencer_if sif ();

    alu_shift_sequencer dut (
        .clk      (clk),
        .notReset (notReset),
        .bus      (sif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU shift path: drives a junk pattern when its output is tri-stated
    always_comb begin
        sif.alu_y    = 16'hDEAD;
        sif.alu_cout = 1'b0;
        if (!sif.alu_notShiftOE) begin
            if (sif.alu_f == FLeft) begin
                sif.alu_y    = {sif.alu_a[14:0], 1'b0};
                sif.alu_cout = sif.alu_a[15];
            end else if (sif.alu_f == FRight) begin
                sif.alu_y    = {1'b0, sif.alu_a[15:1]};
                sif.alu_cout = sif.alu_a[0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts busy / shift-enable cycles and scores each done pulse
    always @(negedge clk) begin
        if (!notReset) begin
            busy_cnt = 0;
            oe_cnt   = 0;
        end else begin
            if (sif.busy) busy_cnt++;
            if (!sif.alu_notShiftOE) oe_cnt++;
            if (sif.done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", {16'h0, sif.result}, {16'h0, e.res});
                    check("carry", {31'h0, sif.carry}, {31'h0, e.cy});
                    check("zero", {31'h0, sif.zero}, {31'h0, (e.res == 16'h0000)});
                    check("latency", cyc - e.acc_cyc, e.amt);
                    check("busy_cycles", busy_cnt, e.amt + 1);
                    check("shift_oe_cycles", oe_cnt, e.amt);
                    check("alu_f", {27'h0, sif.alu_f}, {27'h0, (e.d ? FLeft : FRight)});
                end
                busy_cnt = 0;
                oe_cnt   = 0;
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (sif.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [15:0] op, input logic d, input logic [3:0] amt,
                         input logic [15:0] er, input logic ec, input bit expect_it);
        exp_t e;
        wait_idle();
        sif.start   = 1'b1;
        sif.operand = op;
        sif.dir     = d;
        sif.amount  = amt;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        if (expect_it) begin
            e.res = er; e.cy = ec; e.d = d; e.amt = int'(amt); e.acc_cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'h0, sif.busy}, 32'd0);
        check({tag, "_done"}, {31'h0, sif.done}, 32'd0);
        check({tag, "_result"}, {16'h0, sif.result}, 32'd0);
        check({tag, "_carry"}, {31'h0, sif.carry}, 32'd0);
        check({tag, "_zero"}, {31'h0, sif.zero}, 32'd1);
        check({tag, "_alu_a"}, {16'h0, sif.alu_a}, 32'd0);
        check({tag, "_oe"}, {31'h0, sif.alu_notShiftOE}, 32'd1);
        check({tag, "_alu_f"}, {27'h0, sif.alu_f}, {27'h0, FRight});
    endtask

    initial begin
        exp_t e;
        int guard;
        // Reset with start held high: nothing may be accepted
        sif.start   = 1'b1;
        sif.operand = 16'h8001;
        sif.dir     = 1'b1;
        sif.amount  = 4'd1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        notReset = 1'b1;
        #1;
        check("busy_after_release", {31'h0, sif.busy}, 32'd0);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        e.res = 16'h0002; e.cy = 1'b1; e.d = 1'b1; e.amt = 1; e.acc_cyc = cyc;
        q.push_back(e);

        issue(16'h0001, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b1);

        // Long shift with ignored start pulses while busy
        issue(16'hFFFF, 1'b1, 4'd15, 16'h8000, 1'b1, 1'b1);
        @(negedge clk);
        sif.start = 1'b1; sif.operand = 16'h5555; sif.amount = 4'd2;
        repeat (3) @(negedge clk);
        sif.start = 1'b0;

        // Zero amount, plus a start pulse during its single DONE cycle
        issue(16'h1234, 1'b0, 4'd0, 16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        sif.start = 1'b1; sif.operand = 16'hBEEF; sif.amount = 4'd3;
        @(posedge clk);
        #1;
        sif.start = 1'b0;

        issue(16'h00F0, 1'b0, 4'd5, 16'h0007, 1'b1, 1'b1);

        // Abort mid-shift: no done and result cleared
        issue(16'hF0F0, 1'b0, 4'd8, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        notReset = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        notReset = 1'b1;

        issue(16'hF0F0, 1'b0, 4'd4, 16'h0F0F, 1'b0, 1'b1);

        guard = 0;
        while ((q.size() != 0 || sif.busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
